// File: rtl/mac_sequencer.sv
// mac_sequencer: drives a pipelined P = A*B + C DSP slice through one
// dot product, feeding each partial sum back into C with 28-bit clamping.
module mac_sequencer #(
  parameter int DATA_W  = 16,
  parameter int C_W     = 28,
  parameter int P_W     = 34,
  parameter int MAC_LAT = 3,
  parameter int LEN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [C_W-1:0]    bias,
  output logic              busy,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              dsp_ce,
  output logic              dsp_sclr,
  output logic [DATA_W-1:0] dsp_a,
  output logic [DATA_W-1:0] dsp_b,
  output logic [C_W-1:0]    dsp_c,
  input  logic [P_W-1:0]    dsp_p,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [P_W-1:0]    res_data,
  output logic              res_sat
);

  localparam int WC_W = $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, CLR, ISSUE, WAIT, DONE
  } state_t;

  state_t state, state_n;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [WC_W-1:0]  wcnt;
  logic [C_W-1:0]   acc_c;

  logic             hs;
  logic             last;
  logic [LEN_W:0]   cnt_inc;
  logic [P_W-C_W:0] p_hi;
  logic             ovf;
  logic [C_W-1:0]   p_clamp;

  assign hs      = op_valid & op_ready;
  assign cnt_inc = {1'b0, cnt} + (LEN_W+1)'(1);
  assign last    = (cnt_inc == {1'b0, len_q});

  // P fits in C only if all bits above the C sign bit match it
  assign p_hi    = dsp_p[P_W-1:C_W-1];
  assign ovf     = !((&p_hi) || !(|p_hi));
  assign p_clamp = !ovf ? dsp_p[C_W-1:0] :
                   dsp_p[P_W-1] ? {1'b1, {(C_W-1){1'b0}}}
                                : {1'b0, {(C_W-1){1'b1}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b1;
    op_ready  = 1'b0;
    dsp_ce    = 1'b0;
    dsp_sclr  = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = (len != '0) ? CLR : DONE;
      end
      CLR: begin
        dsp_ce   = 1'b1;
        dsp_sclr = 1'b1;
        state_n  = ISSUE;
      end
      ISSUE: begin
        dsp_ce   = 1'b1;
        op_ready = 1'b1;
        if (op_valid) state_n = WAIT;
      end
      WAIT: begin
        dsp_ce = 1'b1;
        if (wcnt == '0) state_n = last ? DONE : ISSUE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      acc_c    <= '0;
      dsp_a    <= '0;
      dsp_b    <= '0;
      dsp_c    <= '0;
      res_data <= '0;
      res_sat  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            res_sat <= 1'b0;
            if (len != '0) begin
              len_q <= len;
              acc_c <= bias;
              cnt   <= '0;
            end else begin
              res_data <= {{(P_W-C_W){bias[C_W-1]}}, bias};
            end
          end
        end
        ISSUE: begin
          if (hs) begin
            dsp_a <= op_a;
            dsp_b <= op_b;
            dsp_c <= acc_c;
            wcnt  <= WC_W'(MAC_LAT);
          end
        end
        WAIT: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - WC_W'(1);
          end else if (last) begin
            res_data <= dsp_p;
          end else begin
            acc_c <= p_clamp;
            cnt   <= cnt + LEN_W'(1);
            if (ovf) res_sat <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed checks of mac_sequencer against a small
// behavioural model of the 3-stage DSP slice.
module tb_mac_sequencer;

  localparam int DATA_W  = 16;
  localparam int C_W     = 28;
  localparam int P_W     = 34;
  localparam int MAC_LAT = 3;
  localparam int LEN_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [C_W-1:0]    bias;
  logic              busy;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              dsp_ce;
  logic              dsp_sclr;
  logic [DATA_W-1:0] dsp_a;
  logic [DATA_W-1:0] dsp_b;
  logic [C_W-1:0]    dsp_c;
  logic [P_W-1:0]    dsp_p;
  logic              res_valid;
  logic              res_ready;
  logic [P_W-1:0]    res_data;
  logic              res_sat;

  always #5 clk = ~clk;

  mac_sequencer #(
    .DATA_W (DATA_W),
    .C_W    (C_W),
    .P_W    (P_W),
    .MAC_LAT(MAC_LAT),
    .LEN_W  (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .bias     (bias),
    .busy     (busy),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .dsp_ce   (dsp_ce),
    .dsp_sclr (dsp_sclr),
    .dsp_a    (dsp_a),
    .dsp_b    (dsp_b),
    .dsp_c    (dsp_c),
    .dsp_p    (dsp_p),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_sat  (res_sat)
  );

  // DSP slice: three register stages, so P follows A/B/C after 3 edges
  logic signed [P_W-1:0] s1, s2, s3;
  always @(posedge clk) begin
    if (dsp_sclr) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (dsp_ce) begin
      s1 <= P_W'($signed(dsp_a) * $signed(dsp_b)) + P_W'($signed(dsp_c));
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign dsp_p = s3;

  int sclr_cnt = 0;
  int ce_cnt   = 0;
  int hs_cnt   = 0;
  int bad_rdy  = 0;
  always @(posedge clk) begin
    if (dsp_sclr) sclr_cnt++;
    if (dsp_ce) ce_cnt++;
    if (op_valid && op_ready) hs_cnt++;
    if (op_ready && (dsp_sclr || res_valid || !busy)) bad_rdy++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  longint pa[8];
  longint pb[8];
  int     pgap[8];

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      op_valid = 1'b0;
      repeat (pgap[i]) @(negedge clk);
      op_a     = DATA_W'(pa[i]);
      op_b     = DATA_W'(pb[i]);
      op_valid = 1'b1;
      for (int t = 0; t < 100 && !op_ready; t++) @(negedge clk);
      @(negedge clk);
    end
    op_valid = 1'b0;
  endtask

  task automatic run(input int n, input longint bias_v, output int lat);
    int l;
    l     = 0;
    start = 1'b1;
    len   = LEN_W'(n);
    bias  = C_W'(bias_v);
    fork
      feed(n);
      begin
        @(negedge clk);
        start = 1'b0;
        l = 1;
        while (!res_valid && l < 400) begin
          @(negedge clk);
          l++;
        end
      end
    join
    lat = l;
    check("res_valid", res_valid, 1);
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_after_ack", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int lat, s0, h0, c0, t;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    bias      = '0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_ce", dsp_ce, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_dsp_c", dsp_c, 0);
    rst = 1'b0;
    @(negedge clk);

    // single term
    pa[0] = 3; pb[0] = 4; pgap[0] = 0;
    s0 = sclr_cnt;
    run(1, 10, lat);
    check("t1_lat", lat, 7);
    check("t1_data", $signed(res_data), 22);
    check("t1_sat", res_sat, 0);
    check("t1_sclr", sclr_cnt - s0, 1);
    ack();

    // four terms with operand gaps
    pa[0] = 1;   pb[0] = 2;   pgap[0] = 0;
    pa[1] = -3;  pb[1] = 4;   pgap[1] = 1;
    pa[2] = 100; pb[2] = 100; pgap[2] = 3;
    pa[3] = -1;  pb[3] = -1;  pgap[3] = 2;
    s0 = sclr_cnt;
    h0 = hs_cnt;
    run(4, -5, lat);
    check("t2_data", $signed(res_data), 9986);
    check("t2_sat", res_sat, 0);
    check("t2_sclr", sclr_cnt - s0, 1);
    check("t2_hs", hs_cnt - h0, 4);
    check("t2_ready_only_issue", bad_rdy, 0);
    ack();

    // zero-length command
    c0 = ce_cnt;
    h0 = hs_cnt;
    run(0, -7, lat);
    check("t3_lat", lat, 1);
    check("t3_data", $signed(res_data), -7);
    check("t3_ce", ce_cnt - c0, 0);
    check("t3_hs", hs_cnt - h0, 0);
    ack();

    // feedback saturation
    for (int i = 0; i < 3; i++) begin
      pa[i] = 32767; pb[i] = 32767; pgap[i] = 0;
    end
    run(3, 0, lat);
    check("t4_lat", lat, 17);
    check("t4_data", $signed(res_data), 1207894016);
    check("t4_sat", res_sat, 1);
    ack();

    // start pulses in WAIT and DONE, result backpressure
    pa[0] = 2; pb[0] = 3; pgap[0] = 0;
    pa[1] = 4; pb[1] = 5; pgap[1] = 0;
    fork
      run(2, 100, lat);
      begin
        repeat (4) @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(1);
        bias  = '0;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check("t5_data", $signed(res_data), 126);
    start = 1'b1;
    len   = LEN_W'(1);
    bias  = '0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", res_valid, 1);
      check("t5_hold_data", $signed(res_data), 126);
      @(negedge clk);
    end
    ack();
    @(negedge clk);
    check("t5_no_restart", busy, 0);

    // async reset during WAIT of term 2
    h0       = hs_cnt;
    start    = 1'b1;
    len      = LEN_W'(2);
    bias     = C_W'(1);
    op_a     = DATA_W'(5);
    op_b     = DATA_W'(5);
    op_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (hs_cnt - h0 < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t6_reach_term2", hs_cnt - h0, 2);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_op_ready", op_ready, 0);
    check("t6_ce", dsp_ce, 0);
    check("t6_sclr", dsp_sclr, 0);
    check("t6_res_valid", res_valid, 0);
    check("t6_res_sat", res_sat, 0);
    check("t6_dsp_a", dsp_a, 0);
    check("t6_dsp_b", dsp_b, 0);
    check("t6_dsp_c", dsp_c, 0);
    check("t6_res_data", res_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    pa[0] = 3; pb[0] = 4; pgap[0] = 0;
    s0 = sclr_cnt;
    run(1, 10, lat);
    check("t6_lat", lat, 7);
    check("t6_data", $signed(res_data), 22);
    check("t6_sclr_fresh", sclr_cnt - s0, 1);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
